debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  Parametrised multi-channel input conditioner for board sensors and carriage end-stops.
//  Each channel is synchronised, optionally inverted, sampled on a prescaled tick and debounced with hysteresis.
//  A debounced output changes only after DEPTH agreeing samples; a single disagreeing sample does not release it.
//  Provides per-channel rise/fall pulses. Optionally provides a latched change-event record for the scan/encoding logic.
// PARAMETERS
//  CHANNELS  14     number of input channels (10 sensors + 4 boundaries), 1..32
//  DEPTH     8      consecutive agreeing samples needed to change state, 2..16
//  DIV       500    clk cycles per sample tick, >=1 (DIV=1: sample every cycle)
//  INVERT    '1     per-channel bit mask; 1 = input is active-low, inverted after sync
// PORTS
//  clk        in   1         system clock (50 MHz)
//  reset      in   1         synchronous, active-high
//  raw_in     in   CHANNELS  asynchronous pin inputs
//  state      out  CHANNELS  debounced level, active-high after INVERT
//  rise       out  CHANNELS  1-cycle pulse when state goes 0->1
//  fall       out  CHANNELS  1-cycle pulse when state goes 1->0
//  evt_valid  out  1         change event pending (DEBOUNCE_EVENT_EN only, else tied 0)
//  evt_mask   out  CHANNELS  channels changed since last ack (DEBOUNCE_EVENT_EN only, else 0)
//  evt_overrun out 1         sticky: a masked channel changed again before ack (DEBOUNCE_EVENT_EN only, else 0)
//  evt_ack    in   1         consumer acknowledge, 1-cycle pulse
// BEHAVIOUR
//  - Reset: all sync flops, sample windows, state, rise, fall, evt_* = 0; prescaler count = 0.
//  - Reset mid-operation discards partial windows and any pending event. No pulses are emitted on reset.
//  - Sync: 2-flop synchroniser per channel, then XOR with INVERT.
//  - Prescaler: counter 0..DIV-1 with width $clog2(DIV)+1. tick=1 in the cycle the count is DIV-1, which wraps it to 0.
//  - On tick each channel shifts its synced bit into a DEPTH-bit window.
//  - In the cycle after the shift, if the window is all 1 and state=0: state<=1 and rise=1.
//  - If the window is all 0 and state=1: state<=0 and fall=1. Otherwise state holds.
//  - Latency: stable pin change to state change = 2 sync + DEPTH ticks + 1 clk, ±1 tick of phase.
//  - rise/fall are asserted only in the cycle state changes; never both at once on one channel.
//  - Event path (DEBOUNCE_EVENT_EN): chg = rise|fall.
//      States: IDLE (evt_valid=0) and PEND (evt_valid=1).
//      IDLE & chg!=0 -> PEND, evt_mask<=chg (valid the cycle after the change).
//      PEND & !ack: evt_mask<=evt_mask|chg; evt_overrun<=1 if (evt_mask & chg)!=0.
//      PEND & ack & chg==0 -> IDLE, evt_mask<=0.
//      PEND & ack & chg!=0 -> stay PEND, evt_mask<=chg. No change is lost on simultaneous events.
//      evt_overrun clears only on ack, or on reset.
//      evt_ack in IDLE is ignored.
// CONFIGURATION
//  DEBOUNCE_EVENT_EN defined: event FSM, evt_mask register and overrun flag are built.
//  DEBOUNCE_EVENT_EN undefined: evt_valid, evt_mask and evt_overrun are tied to 0 and evt_ack is unused. State, rise and fall are unaffected.
// STRUCTURE
//  Package debounce_pkg holds:
//    - event state encoding (EVT_IDLE, EVT_PEND)
//    - channel index constants (CH_SENSOR0..9, CH_BOUND_N/S/E/W)
//    - default DEPTH/DIV constants
//  Sub-module debounce_channel: sync, invert, window, state and rise/fall for one bit.
//    Instantiated CHANNELS times in a generate loop. The prescaler tick is shared.
//  Event FSM stays in the top level.
// TESTING
//  1 Reset: hold reset 3 cycles with raw_in=all 0 and INVERT=all 1 -> state=0, no rise/fall pulses, evt_valid=0.
//  2 Clean edge: DIV=4, DEPTH=8; raw_in[0] 1->0 held -> state[0]=1 within 2+32+4+1 clk; one rise[0] pulse; evt_mask=0x0001.
//  3 Bounce: toggle ch3 every 3 ticks for 40 ticks, then hold -> no state change until 8 agreeing ticks; exactly one rise.
//  4 Hysteresis: after state=1, inject a single-tick glitch -> state stays 1 and no fall pulse.
//  5 Simultaneous: ack in the same cycle as a ch5 change while PEND on ch2 -> evt_valid stays 1, evt_mask=0x0020, overrun=0.
//  6 Overrun: ch2 rises then falls with no ack -> evt_overrun=1, evt_mask=0x0004; ack -> evt_valid=0, evt_overrun=0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and event-state encoding for the debounce_bank input conditioner.
package debounce_pkg;

  typedef enum logic {
    EVT_IDLE = 1'b0,
    EVT_PEND = 1'b1
  } evt_state_t;

  localparam int NUM_CHANNELS  = 14;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_DIV   = 500;

  localparam int CH_SENSOR0 = 0;
  localparam int CH_SENSOR1 = 1;
  localparam int CH_SENSOR2 = 2;
  localparam int CH_SENSOR3 = 3;
  localparam int CH_SENSOR4 = 4;
  localparam int CH_SENSOR5 = 5;
  localparam int CH_SENSOR6 = 6;
  localparam int CH_SENSOR7 = 7;
  localparam int CH_SENSOR8 = 8;
  localparam int CH_SENSOR9 = 9;
  localparam int CH_BOUND_N = 10;
  localparam int CH_BOUND_S = 11;
  localparam int CH_BOUND_E = 12;
  localparam int CH_BOUND_W = 13;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, polarity fix, DEPTH-sample window
// and hysteretic state with registered rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEPTH = DEFAULT_DEPTH,
  parameter logic INV   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic state,
  output logic rise,
  output logic fall
);

  logic             sync_p0;
  logic             sync_p1;
  logic             synced;
  logic [DEPTH-1:0] window_p2;

  assign synced = sync_p1 ^ INV;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      window_p2 <= '0;
      state     <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      // stage 0/1: metastability filter
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage 2: sample window advances on the shared prescaler tick
      if (tick) begin
        window_p2 <= {window_p2[DEPTH-2:0], synced};
      end
      // stage 3: state only moves on a unanimous window
      rise <= 1'b0;
      fall <= 1'b0;
      if ((&window_p2) && !state) begin
        state <= 1'b1;
        rise  <= 1'b1;
      end else if (!(|window_p2) && state) begin
        state <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debounced input conditioner with shared sample prescaler.
// Optional change-event record built when DEBOUNCE_EVENT_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS = NUM_CHANNELS,
  parameter int                  DEPTH    = DEFAULT_DEPTH,
  parameter int                  DIV      = DEFAULT_DIV,
  parameter logic [CHANNELS-1:0] INVERT   = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                evt_valid,
  output logic [CHANNELS-1:0] evt_mask,
  output logic                evt_overrun,
  input  logic                evt_ack
);

  localparam int CNT_W = $clog2(DIV) + 1;

  logic [CNT_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEPTH (DEPTH),
      .INV   (INVERT[i])
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_in[i]),
      .tick  (tick),
      .state (state[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

`ifdef DEBOUNCE_EVENT_EN
  evt_state_t          evt_state, evt_state_nxt;
  logic [CHANNELS-1:0] mask_q, mask_nxt;
  logic                ovr_q, ovr_nxt;
  logic [CHANNELS-1:0] chg;

  assign chg = rise | fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_state <= EVT_IDLE;
      mask_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      evt_state <= evt_state_nxt;
      mask_q    <= mask_nxt;
      ovr_q     <= ovr_nxt;
    end
  end

  // An ack that coincides with fresh changes re-arms with those changes
  always_comb begin
    evt_state_nxt = evt_state;
    mask_nxt      = mask_q;
    ovr_nxt       = ovr_q;
    case (evt_state)
      EVT_IDLE: begin
        if (|chg) begin
          evt_state_nxt = EVT_PEND;
          mask_nxt      = chg;
        end
      end
      EVT_PEND: begin
        if (evt_ack) begin
          ovr_nxt  = 1'b0;
          mask_nxt = chg;
          if (!(|chg)) begin
            evt_state_nxt = EVT_IDLE;
          end
        end else begin
          mask_nxt = mask_q | chg;
          if (|(mask_q & chg)) begin
            ovr_nxt = 1'b1;
          end
        end
      end
      default: evt_state_nxt = EVT_IDLE;
    endcase
  end

  assign evt_valid   = (evt_state == EVT_PEND);
  assign evt_mask    = mask_q;
  assign evt_overrun = ovr_q;
`else
  logic unused_evt_ack;

  assign unused_evt_ack = evt_ack;
  assign evt_valid      = 1'b0;
  assign evt_mask       = '0;
  assign evt_overrun    = 1'b0;
`endif

endmodule
